// File: rtl/cpu_ctrl_hs.sv
// Multi-cycle instruction sequencer for the 16-bit CPU: handshaked memory accesses,
// wait-timeout error trap and single-step debug pause between instructions.
module cpu_ctrl_hs #(
    parameter int TO_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] cond,
    input  logic [2:0] status,
    input  logic       mem_ready,
    input  logic       step_en,
    input  logic       step_go,
    output logic [8:0] to_dp,
    output logic [2:0] nsel,
    output logic [3:0] pc_sel,
    output logic       load_pc,
    output logic       addr_sel,
    output logic       load_ir,
    output logic       load_addr,
    output logic [1:0] mem_cmd,
    output logic       halt,
    output logic       mem_err,
    output logic       instr_done
);

    typedef enum logic [4:0] {
        st_reset, st_if, st_upd, st_dec, st_geta, st_getb, st_math, st_zero,
        st_wb, st_wimm, st_mem, st_mem2, st_ldr, st_stb, st_stc, st_stw,
        st_br, st_calld, st_calli, st_ret1, st_ret2, st_ret3, st_step,
        st_halt, st_err
    } state_t;

    // to_dp = {asel, bsel, write, vsel[1:0], loads, loadc, loadb, loada}
    localparam logic [8:0] DP_ASEL  = 9'h100;
    localparam logic [8:0] DP_BSEL  = 9'h080;
    localparam logic [8:0] DP_WRITE = 9'h040;
    localparam logic [8:0] DP_V_MEM = 9'h000;
    localparam logic [8:0] DP_V_IMM = 9'h010;
    localparam logic [8:0] DP_V_PC  = 9'h020;
    localparam logic [8:0] DP_V_C   = 9'h030;
    localparam logic [8:0] DP_LOADS = 9'h008;
    localparam logic [8:0] DP_LOADC = 9'h004;
    localparam logic [8:0] DP_LOADB = 9'h002;
    localparam logic [8:0] DP_LOADA = 9'h001;

    localparam logic [2:0] N_RN = 3'b100;
    localparam logic [2:0] N_RD = 3'b010;
    localparam logic [2:0] N_RM = 3'b001;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          state, state_next, done_next;
    logic [TO_W-1:0] wait_cnt;
    logic            waiting, timed_out, taken;
    logic [4:0]      opfn;

    assign opfn      = {opcode, op};
    assign waiting   = state inside {st_if, st_ldr, st_stw};
    assign timed_out = (TIMEOUT != 0) && waiting && !mem_ready && (wait_cnt == TO_LAST);
    assign done_next = step_en ? st_step : st_if;

    // status = {V, N, Z}
    always_comb begin
        case (cond)
            3'b000:  taken = 1'b1;
            3'b001:  taken = status[0];
            3'b010:  taken = !status[0];
            3'b011:  taken = status[1] ^ status[2];
            3'b100:  taken = (status[1] ^ status[2]) | status[0];
            default: taken = 1'b0;
        endcase
    end

    // Counter is cleared in every non-waiting state, which covers the clear-on-entry rule.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= st_reset;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (waiting && !mem_ready && !timed_out)
                wait_cnt <= wait_cnt + TO_W'(1);
            else
                wait_cnt <= '0;
            if (timed_out)
                mem_err <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            st_reset: state_next = st_if;
            st_if: begin
                if (timed_out)      state_next = st_err;
                else if (mem_ready) state_next = st_upd;
            end
            st_upd: state_next = st_dec;
            st_dec: begin
                if (opcode == 3'b111)                     state_next = st_halt;
                else if (opcode == 3'b110 && op == 2'b10) state_next = st_wimm;
                else if (opcode == 3'b110)                state_next = st_getb;
                else if (opcode == 3'b001)                state_next = st_br;
                else if (opcode == 3'b010) begin
                    if (op == 2'b11)      state_next = st_calld;
                    else if (op == 2'b10) state_next = st_calli;
                    else                  state_next = st_ret1;
                end else                                  state_next = st_geta;
            end
            st_geta: state_next = (opcode == 3'b101) ? st_getb : st_mem;
            st_getb: state_next = (opfn == 5'b11000 || opfn == 5'b10111) ? st_zero : st_math;
            st_math: state_next = (opfn == 5'b10101) ? done_next : st_wb;
            st_zero: state_next = st_wb;
            st_wb, st_wimm, st_br, st_calld, st_ret3: state_next = done_next;
            st_mem:  state_next = st_mem2;
            st_mem2: state_next = (opcode == 3'b011) ? st_ldr : st_stb;
            st_ldr, st_stw: begin
                if (timed_out)      state_next = st_err;
                else if (mem_ready) state_next = done_next;
            end
            st_stb:   state_next = st_stc;
            st_stc:   state_next = st_stw;
            st_calli: state_next = st_ret1;
            st_ret1:  state_next = st_ret2;
            st_ret2:  state_next = st_ret3;
            st_step:  if (step_go) state_next = st_if;
            st_halt:  state_next = st_halt;
            st_err:   state_next = st_err;
            default:  state_next = st_halt;
        endcase
    end

    always_comb begin
        to_dp      = '0;
        nsel       = '0;
        pc_sel     = 4'b0001;
        load_pc    = 1'b0;
        addr_sel   = 1'b0;
        load_ir    = 1'b0;
        load_addr  = 1'b0;
        mem_cmd    = 2'b00;
        halt       = 1'b0;
        instr_done = 1'b0;
        case (state)
            st_reset: begin
                load_pc = 1'b1;
                pc_sel  = 4'b1000;
            end
            st_if: begin
                addr_sel = 1'b1;
                mem_cmd  = 2'b01;
                load_ir  = mem_ready;
            end
            st_upd: load_pc = 1'b1;
            st_geta: begin
                to_dp = DP_LOADA;
                nsel  = N_RN;
            end
            st_getb: begin
                to_dp = DP_LOADB;
                nsel  = N_RM;
            end
            st_math: begin
                to_dp      = DP_LOADC | DP_LOADS;
                instr_done = (opfn == 5'b10101);
            end
            st_zero: to_dp = DP_ASEL | DP_LOADC | DP_LOADS;
            st_wb: begin
                to_dp      = DP_WRITE | DP_V_C;
                nsel       = N_RD;
                instr_done = 1'b1;
            end
            st_wimm: begin
                to_dp      = DP_WRITE | DP_V_IMM;
                nsel       = N_RN;
                instr_done = 1'b1;
            end
            st_mem:  to_dp = DP_BSEL | DP_LOADC;
            st_mem2: load_addr = 1'b1;
            st_ldr: begin
                mem_cmd = 2'b01;
                if (mem_ready) begin
                    to_dp      = DP_WRITE | DP_V_MEM;
                    nsel       = N_RD;
                    instr_done = 1'b1;
                end
            end
            st_stb: begin
                to_dp = DP_LOADB;
                nsel  = N_RD;
            end
            st_stc: to_dp = DP_ASEL | DP_LOADC;
            st_stw: begin
                mem_cmd    = 2'b10;
                instr_done = mem_ready;
            end
            st_br: begin
                instr_done = 1'b1;
                if (taken) begin
                    load_pc = 1'b1;
                    pc_sel  = 4'b0010;
                end
            end
            st_calld: begin
                to_dp      = DP_WRITE | DP_V_PC;
                nsel       = N_RN;
                load_pc    = 1'b1;
                pc_sel     = 4'b0010;
                instr_done = 1'b1;
            end
            st_calli: begin
                to_dp = DP_WRITE | DP_V_PC;
                nsel  = N_RN;
            end
            st_ret1: begin
                to_dp = DP_LOADB;
                nsel  = N_RD;
            end
            st_ret2: to_dp = DP_ASEL | DP_LOADC;
            st_ret3: begin
                load_pc    = 1'b1;
                pc_sel     = 4'b0100;
                instr_done = 1'b1;
            end
            st_halt, st_err: halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_hs.sv
// Randomised scoreboard bench for cpu_ctrl_hs: an instruction-level model expands each
// instruction into its expected per-cycle output trace; a monitor compares every cycle.
module tb_cpu_ctrl_hs;
    localparam int TO_W    = 4;
    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       reset, mem_ready, step_en, step_go;
    logic [2:0] opcode, cond, status;
    logic [1:0] op;
    logic [8:0] to_dp;
    logic [2:0] nsel;
    logic [3:0] pc_sel;
    logic       load_pc, addr_sel, load_ir, load_addr, halt, mem_err, instr_done;
    logic [1:0] mem_cmd;

    always #5 clk = ~clk;

    cpu_ctrl_hs #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond), .status(status),
        .mem_ready(mem_ready), .step_en(step_en), .step_go(step_go), .to_dp(to_dp),
        .nsel(nsel), .pc_sel(pc_sel), .load_pc(load_pc), .addr_sel(addr_sel),
        .load_ir(load_ir), .load_addr(load_addr), .mem_cmd(mem_cmd), .halt(halt),
        .mem_err(mem_err), .instr_done(instr_done)
    );

    typedef struct packed {
        logic [8:0] dp;
        logic [2:0] nsel;
        logic [3:0] pc_sel;
        logic       load_pc, addr_sel, load_ir, load_addr;
        logic [1:0] mem_cmd;
        logic       halt, mem_err, done;
    } out_t;

    typedef struct {
        out_t  e;
        string tag;
    } item_t;

    item_t sb[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    step_n = -1;

    function automatic out_t base();
        out_t o;
        o = '0;
        o.pc_sel = 4'b0001;
        return o;
    endfunction

    function automatic logic [8:0] dpv(input bit a, input bit b, input bit w, input logic [1:0] v,
                                       input bit ls, input bit lc, input bit lb, input bit la);
        return {a, b, w, v, ls, lc, lb, la};
    endfunction

    function automatic out_t dpo(input logic [8:0] d, input logic [2:0] n);
        out_t o;
        o = base();
        o.dp = d;
        o.nsel = n;
        return o;
    endfunction

    task automatic emit_x(input out_t e, input logic mr, input logic go, input string tag);
        item_t it;
        mem_ready = mr;
        step_go   = go;
        it.e   = e;
        it.tag = tag;
        sb.push_back(it);
        @(negedge clk);
    endtask

    // Inputs that the current state must ignore are randomised.
    task automatic emit(input out_t e, input string tag);
        emit_x(e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tag);
    endtask

    task automatic do_reset(input out_t cur);
        out_t x;
        reset = 1'b1;
        emit_x(cur, 1'b0, 1'($urandom_range(0, 1)), "RST_ASSERT");
        reset = 1'b0;
        x = base();
        x.load_pc = 1'b1;
        x.pc_sel = 4'b1000;
        emit(x, "RESET");
    endtask

    task automatic err_run();
        out_t x;
        x = base();
        x.halt = 1'b1;
        x.mem_err = 1'b1;
        repeat (20) emit(x, "ERR");
        do_reset(x);
    endtask

    // lat low cycles then one ready cycle; may divert into the timeout trap or a reset.
    task automatic do_wait(input out_t w, input out_t r, input int lat, input int abort,
                           output bit stop);
        stop = 1'b0;
        for (int i = 0; i <= lat; i++) begin
            if (TIMEOUT != 0 && i == TIMEOUT) begin
                err_run();
                stop = 1'b1;
                return;
            end
            if (i == abort) begin
                do_reset(w);
                stop = 1'b1;
                return;
            end
            if (i == lat) emit_x(r, 1'b1, 1'($urandom_range(0, 1)), "WAIT_RDY");
            else          emit_x(w, 1'b0, 1'($urandom_range(0, 1)), "WAIT_LOW");
        end
    endtask

    task automatic step_tail(input bit se);
        int   n;
        out_t z;
        z = base();
        if (!se) return;
        n = (step_n > 0) ? step_n : $urandom_range(1, 6);
        for (int i = 0; i < n; i++) begin
            step_en = 1'($urandom_range(0, 1));
            emit_x(z, 1'($urandom_range(0, 1)), 1'b0, "STEP");
        end
        emit_x(z, 1'($urandom_range(0, 1)), 1'b1, "STEP_GO");
    endtask

    task automatic fin(input out_t x, input bit se, input string tag);
        x.done = 1'b1;
        emit(x, tag);
        step_tail(se);
    endtask

    function automatic bit br_taken(input logic [2:0] c, input logic [2:0] st);
        bit v, n, z;
        {v, n, z} = st;
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return n != v;
            3'd4:    return (n != v) || z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic getb_path(input logic [4:0] f, input bit se);
        emit(dpo(dpv(0,0,0,2'b00,0,0,1,0), 3'b001), "GETB");
        if (f == 5'b11000 || f == 5'b10111) begin
            emit(dpo(dpv(1,0,0,2'b00,1,1,0,0), 3'b000), "ZERO");
            fin(dpo(dpv(0,0,1,2'b11,0,0,0,0), 3'b010), se, "WB");
        end else if (f == 5'b10101) begin
            fin(dpo(dpv(0,0,0,2'b00,1,1,0,0), 3'b000), se, "CMP");
        end else begin
            emit(dpo(dpv(0,0,0,2'b00,1,1,0,0), 3'b000), "MATH");
            fin(dpo(dpv(0,0,1,2'b11,0,0,0,0), 3'b010), se, "WB");
        end
    endtask

    task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input logic [2:0] c,
                             input logic [2:0] st, input bit se, input int flat, input int mlat,
                             input int abort);
        out_t x, y;
        bit   stop;
        opcode = opc; op = o; cond = c; status = st; step_en = se;
        x = base(); x.addr_sel = 1'b1; x.mem_cmd = 2'b01;
        y = x; y.load_ir = 1'b1;
        do_wait(x, y, flat, -1, stop);
        if (stop) return;
        x = base(); x.load_pc = 1'b1;
        emit(x, "UPD");
        emit(base(), "DEC");
        if (opc == 3'b111) begin
            x = base(); x.halt = 1'b1;
            repeat ($urandom_range(1, 5)) emit(x, "HALT");
            do_reset(x);
        end else if (opc == 3'b110 && o == 2'b10) begin
            fin(dpo(dpv(0,0,1,2'b01,0,0,0,0), 3'b100), se, "WIMM");
        end else if (opc == 3'b110) begin
            getb_path({opc, o}, se);
        end else if (opc == 3'b001) begin
            x = base();
            if (br_taken(c, st)) begin x.load_pc = 1'b1; x.pc_sel = 4'b0010; end
            fin(x, se, "BR");
        end else if (opc == 3'b010 && o == 2'b11) begin
            x = dpo(dpv(0,0,1,2'b10,0,0,0,0), 3'b100);
            x.load_pc = 1'b1; x.pc_sel = 4'b0010;
            fin(x, se, "CALLD");
        end else if (opc == 3'b010) begin
            if (o == 2'b10) emit(dpo(dpv(0,0,1,2'b10,0,0,0,0), 3'b100), "CALLI");
            emit(dpo(dpv(0,0,0,2'b00,0,0,1,0), 3'b010), "RET1");
            emit(dpo(dpv(1,0,0,2'b00,0,1,0,0), 3'b000), "RET2");
            x = base(); x.load_pc = 1'b1; x.pc_sel = 4'b0100;
            fin(x, se, "RET3");
        end else begin
            emit(dpo(dpv(0,0,0,2'b00,0,0,0,1), 3'b100), "GETA");
            if (opc == 3'b101) begin
                getb_path({opc, o}, se);
            end else begin
                emit(dpo(dpv(0,1,0,2'b00,0,1,0,0), 3'b000), "MEM");
                x = base(); x.load_addr = 1'b1;
                emit(x, "MEM2");
                if (opc == 3'b011) begin
                    x = base(); x.mem_cmd = 2'b01;
                    y = dpo(dpv(0,0,1,2'b00,0,0,0,0), 3'b010); y.mem_cmd = 2'b01; y.done = 1'b1;
                end else begin
                    emit(dpo(dpv(0,0,0,2'b00,0,0,1,0), 3'b010), "STB");
                    emit(dpo(dpv(1,0,0,2'b00,0,1,0,0), 3'b000), "STC");
                    x = base(); x.mem_cmd = 2'b10;
                    y = x; y.done = 1'b1;
                end
                do_wait(x, y, mlat, abort, stop);
                if (!stop) step_tail(se);
            end
        end
    endtask

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 99);
        if (r < 50) return 0;
        if (r < 85) return $urandom_range(1, 3);
        if (r < 97) return $urandom_range(4, 14);
        return $urandom_range(15, 16);
    endfunction

    initial begin : monitor
        item_t it;
        out_t  a;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                it = sb.pop_front();
                a = {to_dp, nsel, pc_sel, load_pc, addr_sel, load_ir, load_addr, mem_cmd,
                     halt, mem_err, instr_done};
                vectors++;
                if (a !== it.e) begin
                    miscompares++;
                    $display("FAIL %s @%0t: got dp=%h nsel=%b pc_sel=%b ctl=%b want dp=%h nsel=%b pc_sel=%b ctl=%b",
                             it.tag, $time, a.dp, a.nsel, a.pc_sel, a[8:0],
                             it.e.dp, it.e.nsel, it.e.pc_sel, it.e[8:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        miscompares++;
        $display("FAIL watchdog: got still running want finished");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : stim
        out_t x;
        reset = 1'b1; mem_ready = 1'b0; step_en = 1'b0; step_go = 1'b0;
        opcode = '0; op = '0; cond = '0; status = '0;
        @(negedge clk);
        reset = 1'b0;
        x = base(); x.load_pc = 1'b1; x.pc_sel = 4'b1000;
        emit(x, "RESET");
        run_instr(3'b110, 2'b10, 3'd0, 3'd0, 1'b0, 0, 0, -1);
        run_instr(3'b110, 2'b10, 3'd0, 3'd0, 1'b0, 3, 0, -1);
        run_instr(3'b011, 2'b00, 3'd0, 3'd0, 1'b0, 0, 15, -1);
        run_instr(3'b001, 2'b00, 3'b001, 3'b001, 1'b0, 0, 0, -1);
        run_instr(3'b001, 2'b00, 3'b001, 3'b000, 1'b0, 0, 0, -1);
        step_n = 10;
        run_instr(3'b101, 2'b00, 3'd0, 3'd0, 1'b1, 0, 0, -1);
        step_n = -1;
        run_instr(3'b100, 2'b00, 3'd0, 3'd0, 1'b0, 0, 10, 7);
        run_instr(3'b100, 2'b00, 3'd0, 3'd0, 1'b0, 14, 14, -1);
        for (int k = 0; k < 250; k++) begin
            int mlat, abort;
            mlat  = pick_lat();
            abort = -1;
            if ($urandom_range(0, 19) == 0) begin
                abort = $urandom_range(0, 13);
                mlat  = 14;
            end
            run_instr(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                      3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 3) == 0), pick_lat(), mlat, abort);
        end
        @(negedge clk);
        #5;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
